// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two transmit FIFO.
// The serial line is idle high; bytes go out LSB first, back to back when queued.
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [7:0]                         tx_data,
   input  logic                               tx_valid,
   output logic                               tx_ready,
   output logic                               uart_data,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [BW-1:0]   baud_r, baud_s;
   logic [2:0]      bit_r, bit_s;
   logic [7:0]      shift_r, shift_s;
   logic            line_r, line_s;
   logic            busy_r;
   logic            ready_r;
   logic [CW-1:0]   count_r, count_s;
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic            push_s, pop_s;
   logic [7:0]      head_s;

   assign tx_ready   = ready_r;
   assign uart_data  = line_r;
   assign busy       = busy_r;
   assign fifo_count = count_r;
   assign head_s     = mem_r[rd_ptr_r];

   // Frame sequencing: a pop always happens together with the move into START.
   always_comb begin
      state_s = state_r;
      baud_s  = baud_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      line_s  = line_r;
      pop_s   = 1'b0;
      push_s  = tx_valid && ready_r;
      case (state_r)
         IDLE: begin
            if (count_r != {CW{1'b0}}) begin
               pop_s   = 1'b1;
               shift_s = head_s;
               baud_s  = {BW{1'b0}};
               state_s = START;
               line_s  = 1'b0;
            end else begin
               line_s  = 1'b1;
            end
         end
         START: begin
            if (baud_r == BAUD_LAST) begin
               baud_s  = {BW{1'b0}};
               bit_s   = 3'd0;
               state_s = DATA;
               line_s  = shift_r[0];
            end else begin
               baud_s  = baud_r + BW'(1);
               line_s  = 1'b0;
            end
         end
         DATA: begin
            if (baud_r == BAUD_LAST) begin
               baud_s = {BW{1'b0}};
               if (bit_r == 3'd7) begin
                  state_s = STOP;
                  line_s  = 1'b1;
               end else begin
                  bit_s   = bit_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
                  line_s  = shift_r[1];
               end
            end else begin
               baud_s = baud_r + BW'(1);
            end
         end
         STOP: begin
            if (baud_r == BAUD_LAST) begin
               baud_s = {BW{1'b0}};
               if (count_r != {CW{1'b0}}) begin
                  pop_s   = 1'b1;
                  shift_s = head_s;
                  state_s = START;
                  line_s  = 1'b0;
               end else begin
                  state_s = IDLE;
                  line_s  = 1'b1;
               end
            end else begin
               baud_s = baud_r + BW'(1);
               line_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
            line_s  = 1'b1;
         end
      endcase
   end

   // Occupancy update; simultaneous push and pop cancel out.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CW'(1);
         2'b01:   count_s = count_r - CW'(1);
         default: count_s = count_r;
      endcase
   end

   // FSM, shifter and registered line/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         baud_r  <= {BW{1'b0}};
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         line_r  <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         line_r  <= line_s;
         busy_r  <= (state_s != IDLE);
      end
   end

   // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         ready_r  <= 1'b1;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_s;
         ready_r <= (count_s < DEPTH_C);
      end
   end

endmodule
